// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared processor widths, opcode field layout and fetch FSM states
package fetch_unit_pkg;

    localparam int PROC_PC_W   = 13;
    localparam int PROC_INST_W = 16;
    localparam int FQ_DEPTH    = 2;

    // Opcode lives in the top nibble of every instruction word
    localparam int            OP_LSB  = 12;
    localparam int            OP_W    = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - power-of-two FIFO of {inst, pc} with flush, feeding decode
module fetch_queue #(
    parameter int DEPTH  = 2,
    parameter int INST_W = 16,
    parameter int PC_W   = 13,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output logic [INST_W-1:0] head_inst,
    output logic [PC_W-1:0]   head_pc
);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= push_inst;
                pc_mem[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_inst  = head_valid ? inst_mem[rd_ptr] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction fetch FSM with redirect/squash and HALT stop
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               PC_W     = PROC_PC_W,
    parameter int               INST_W   = PROC_INST_W,
    parameter int               DEPTH    = FQ_DEPTH,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [OP_W-1:0]  HALT_OP  = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    output logic [PC_W-1:0]   id_pc_plus1,
    output logic              halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   fpc_q, fpc_d;
    logic [PC_W-1:0]   squash_pc_q, squash_pc_d;
    logic              req_raw;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic              q_valid;
    logic [INST_W-1:0] q_inst;
    logic [PC_W-1:0]   q_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fpc_q       <= RESET_PC;
            squash_pc_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            squash_pc_q <= squash_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        squash_pc_d = squash_pc_q;
        req_raw     = 1'b0;
        imem_addr   = fpc_q;
        push        = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Issue only when a queue slot is free, so an ack can always be pushed
                req_raw = (count < CNT_W'(DEPTH));
                if (req_raw && imem_ack) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + PC_W'(1);
                    if (imem_rdata[OP_LSB +: OP_W] == HALT_OP) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_SQUASH: begin
                // Finish the stale read at its original address, then drop its data
                req_raw   = 1'b1;
                imem_addr = squash_pc_q;
                if (imem_ack) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                req_raw = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        imem_req = req_raw && rst;

        if (redirect) begin
            push  = 1'b0;
            fpc_d = redirect_pc;
            if (imem_req && !imem_ack) begin
                state_d     = ST_SQUASH;
                squash_pc_d = imem_addr;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    assign pop = q_valid && id_ready && !redirect;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W),
        .PC_W   (PC_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_inst  (imem_rdata),
        .push_pc    (fpc_q),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (q_valid),
        .head_inst  (q_inst),
        .head_pc    (q_pc)
    );

    assign id_valid    = q_valid;
    assign id_inst     = q_inst;
    assign id_pc       = q_pc;
    assign id_pc_plus1 = q_valid ? q_pc + PC_W'(1) : '0;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a latency-programmable imem model
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [12:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_inst;
    logic [12:0] id_pc;
    logic [12:0] id_pc_plus1;
    logic        halted;

    int checks = 0;
    int errors = 0;

    int   lat;
    int   wait_cnt;
    logic halt_en;
    logic stray_ack;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns its address as data; address 5 holds a HALT word when enabled
    always_comb begin
        imem_ack   = stray_ack || (imem_req && (wait_cnt == lat));
        imem_rdata = (halt_en && imem_addr == 13'd5) ? 16'hF000 : {3'b000, imem_addr};
    end

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        lat = 0; wait_cnt = 0; halt_en = 1'b0; stray_ack = 1'b0;
        #3;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_inst", id_inst, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_pc1", id_pc_plus1, 0);

        // 1: streaming from reset
        step(); rst = 1'b1; #2;
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        chk("t1_valid", id_valid, 0);
        for (int k = 0; k < 5; k++) begin
            step(); #2;
            chk("t1_s_valid", id_valid, 1);
            chk("t1_s_pc", id_pc, k);
            chk("t1_s_inst", id_inst, k);
            chk("t1_s_pc1", id_pc_plus1, k + 1);
            chk("t1_s_addr", imem_addr, k + 1);
        end

        // 2: backpressure fills the queue
        step(); id_ready = 1'b0; #2;
        chk("t2_pc_first", id_pc, 5);
        chk("t2_addr_first", imem_addr, 6);
        for (int i = 0; i < 4; i++) begin
            step(); #2;
            chk("t2_req_full", imem_req, 0);
            chk("t2_valid_full", id_valid, 1);
            chk("t2_pc_frozen", id_pc, 5);
            chk("t2_inst_frozen", id_inst, 5);
        end
        step(); id_ready = 1'b1; #2;
        chk("t2_rel_pc", id_pc, 5);
        chk("t2_rel_req", imem_req, 0);
        step(); #2;
        chk("t2_next_pc", id_pc, 6);
        chk("t2_next_req", imem_req, 1);
        chk("t2_next_addr", imem_addr, 7);
        step(); #2;
        chk("t2_after_pc", id_pc, 7);
        chk("t2_after_addr", imem_addr, 8);

        // 3: redirect while a slow read is outstanding
        step(); lat = 2; #2;
        chk("t3_pc", id_pc, 8);
        chk("t3_addr", imem_addr, 9);
        chk("t3_ack", imem_ack, 0);
        step(); redirect = 1'b1; redirect_pc = 13'h100; #2;
        chk("t3_r_valid", id_valid, 0);
        chk("t3_r_addr", imem_addr, 9);
        step(); redirect = 1'b0; #2;
        chk("t3_sq_req", imem_req, 1);
        chk("t3_sq_addr", imem_addr, 9);
        chk("t3_sq_ack", imem_ack, 1);
        step(); #2;
        chk("t3_new_addr", imem_addr, 13'h100);
        chk("t3_drop_valid", id_valid, 0);
        step(); #2;
        chk("t3_wait_valid", id_valid, 0);
        step(); #2;
        chk("t3_new_ack", imem_ack, 1);
        chk("t3_new_addr2", imem_addr, 13'h100);

        // 4: redirect coincident with ack and pop
        step(); lat = 0; redirect = 1'b1; redirect_pc = 13'h40; #2;
        chk("t4_valid", id_valid, 1);
        chk("t4_pc", id_pc, 13'h100);
        chk("t4_inst", id_inst, 16'h0100);
        chk("t4_ack", imem_ack, 1);
        chk("t4_addr", imem_addr, 13'h101);
        step(); redirect = 1'b0; #2;
        chk("t4_flushed", id_valid, 0);
        chk("t4_tgt_addr", imem_addr, 13'h40);

        // 5: HALT at address 5, stray ack, then resume
        step(); redirect = 1'b1; redirect_pc = 13'd3; halt_en = 1'b1; #2;
        chk("t5_pc40", id_pc, 13'h40);
        step(); redirect = 1'b0; #2;
        chk("t5_valid0", id_valid, 0);
        chk("t5_addr3", imem_addr, 3);
        step(); #2;
        chk("t5_pc3", id_pc, 3);
        step(); #2;
        chk("t5_pc4", id_pc, 4);
        chk("t5_addr5", imem_addr, 5);
        chk("t5_not_halted", halted, 0);
        step(); #2;
        chk("t5_halted", halted, 1);
        chk("t5_req_off", imem_req, 0);
        chk("t5_halt_valid", id_valid, 1);
        chk("t5_halt_inst", id_inst, 16'hF000);
        chk("t5_halt_pc", id_pc, 5);
        chk("t5_halt_pc1", id_pc_plus1, 6);
        step(); stray_ack = 1'b1; #2;
        chk("t5_drained", id_valid, 0);
        chk("t5_still_halted", halted, 1);
        chk("t5_no_req", imem_req, 0);
        step(); stray_ack = 1'b0; redirect = 1'b1; redirect_pc = 13'h20; #2;
        chk("t5_stray_ignored", id_valid, 0);
        chk("t5_halted_at_redir", halted, 1);
        step(); redirect = 1'b0; #2;
        chk("t5_resumed", halted, 0);
        chk("t5_res_req", imem_req, 1);
        chk("t5_res_addr", imem_addr, 13'h20);

        // 6: PC wrap, then reset in the middle of a slow read
        step(); redirect = 1'b1; redirect_pc = 13'h1FFF; #2;
        chk("t6_pc20", id_pc, 13'h20);
        step(); redirect = 1'b0; #2;
        chk("t6_addr_top", imem_addr, 13'h1FFF);
        chk("t6_valid0", id_valid, 0);
        step(); #2;
        chk("t6_pc_top", id_pc, 13'h1FFF);
        chk("t6_inst_top", id_inst, 16'h1FFF);
        chk("t6_pc1_wrap", id_pc_plus1, 0);
        chk("t6_addr_wrap", imem_addr, 0);
        step(); lat = 2; #2;
        chk("t6_pc0", id_pc, 0);
        chk("t6_pc1_1", id_pc_plus1, 1);
        chk("t6_slow_ack", imem_ack, 0);
        step(); #2;
        chk("t6_wait_req", imem_req, 1);
        chk("t6_wait_addr", imem_addr, 1);
        #1; rst = 1'b0; halt_en = 1'b0; #1;
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_addr", imem_addr, 0);
        chk("t6_rst_valid", id_valid, 0);
        chk("t6_rst_inst", id_inst, 0);
        chk("t6_rst_pc", id_pc, 0);
        chk("t6_rst_pc1", id_pc_plus1, 0);
        chk("t6_rst_halted", halted, 0);
        step(); lat = 0; rst = 1'b1; #2;
        chk("t6_restart_req", imem_req, 1);
        chk("t6_restart_addr", imem_addr, 0);
        step(); #2;
        chk("t6_restart_valid", id_valid, 1);
        chk("t6_restart_pc", id_pc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
